// File: rtl/fpu_ss_mem_responder.sv
// Core-side responder for CORE-V-XIF x_mem requests from the FPU subsystem.
// Checks alignment, issues each request on OBI and returns in-order single-cycle results.
module fpu_ss_mem_responder #(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    x_mem_valid_i,
  output logic                    x_mem_ready_o,
  input  logic [X_ID_WIDTH-1:0]   x_mem_req_id_i,
  input  logic [ADDR_WIDTH-1:0]   x_mem_req_addr_i,
  input  logic                    x_mem_req_we_i,
  input  logic [DATA_WIDTH/8-1:0] x_mem_req_be_i,
  input  logic [DATA_WIDTH-1:0]   x_mem_req_wdata_i,
  input  logic                    x_mem_req_last_i,
  input  logic                    x_mem_req_spec_i,
  output logic                    x_mem_resp_exc_o,
  output logic [5:0]              x_mem_resp_exccode_o,
  output logic                    x_mem_result_valid_o,
  output logic [X_ID_WIDTH-1:0]   x_mem_result_id_o,
  output logic [DATA_WIDTH-1:0]   x_mem_result_rdata_o,
  output logic                    x_mem_result_err_o,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  output logic [ADDR_WIDTH-1:0]   data_addr_o,
  output logic                    data_we_o,
  output logic [DATA_WIDTH/8-1:0] data_be_o,
  output logic [DATA_WIDTH-1:0]   data_wdata_o,
  input  logic                    data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   data_rdata_i,
  input  logic                    data_err_i
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam logic [5:0] EXC_LOAD_MISALIGNED  = 6'd4;
  localparam logic [5:0] EXC_STORE_MISALIGNED = 6'd6;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);

  typedef enum logic {IDLE, WAIT_GNT} state_e;

  state_e state_q, state_d;

  // Request parked here while OBI withholds the grant, so the bus fields stay stable.
  logic [ADDR_WIDTH-1:0] hold_addr_q;
  logic                  hold_we_q;
  logic [BE_W-1:0]       hold_be_q;
  logic [DATA_WIDTH-1:0] hold_wdata_q;
  logic [X_ID_WIDTH-1:0] hold_id_q;
  logic                  hold_load;

  logic [X_ID_WIDTH-1:0] fifo_id_q [OUTSTANDING];
  logic                  fifo_we_q [OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop, push_we;
  logic [X_ID_WIDTH-1:0] push_id;
  logic                  misaligned;

  // last/spec carry no information from the FPU subsystem.
  logic unused_req_flags;
  assign unused_req_flags = x_mem_req_last_i ^ x_mem_req_spec_i;

  assign fifo_full  = (cnt_q == CNT_W'(OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);
  assign misaligned = (x_mem_req_addr_i[1:0] != 2'b00);

  // NOTE: every output is given a default before any branch so no path leaves a value
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d              = state_q;
    x_mem_ready_o        = 1'b0;
    x_mem_resp_exc_o     = 1'b0;
    x_mem_resp_exccode_o = '0;
    x_mem_result_valid_o = 1'b0;
    x_mem_result_id_o    = '0;
    x_mem_result_rdata_o = '0;
    x_mem_result_err_o   = 1'b0;
    data_req_o           = 1'b0;
    data_addr_o          = '0;
    data_we_o            = 1'b0;
    data_be_o            = '0;
    data_wdata_o         = '0;
    push                 = 1'b0;
    push_id              = '0;
    push_we              = 1'b0;
    hold_load            = 1'b0;
    pop                  = 1'b0;

    // Outputs are forced low for the whole time reset is asserted.
    if (rst_ni) begin
      case (state_q)
        IDLE: begin
          x_mem_ready_o = ~fifo_full;
          data_req_o    = x_mem_valid_i & ~misaligned & ~fifo_full;
          data_addr_o   = x_mem_req_addr_i;
          data_we_o     = x_mem_req_we_i;
          data_be_o     = x_mem_req_be_i;
          data_wdata_o  = x_mem_req_wdata_i;
          if (x_mem_valid_i && !fifo_full) begin
            if (misaligned) begin
              x_mem_resp_exc_o     = 1'b1;
              x_mem_resp_exccode_o = x_mem_req_we_i ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED;
            end else if (data_gnt_i) begin
              push    = 1'b1;
              push_id = x_mem_req_id_i;
              push_we = x_mem_req_we_i;
            end else begin
              hold_load = 1'b1;
              state_d   = WAIT_GNT;
            end
          end
        end
        WAIT_GNT: begin
          data_req_o   = 1'b1;
          data_addr_o  = hold_addr_q;
          data_we_o    = hold_we_q;
          data_be_o    = hold_be_q;
          data_wdata_o = hold_wdata_q;
          if (data_gnt_i) begin
            push    = 1'b1;
            push_id = hold_id_q;
            push_we = hold_we_q;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (data_rvalid_i && !fifo_empty) begin
        pop                  = 1'b1;
        x_mem_result_valid_o = 1'b1;
        x_mem_result_id_o    = fifo_id_q[rd_ptr_q];
        x_mem_result_rdata_o = fifo_we_q[rd_ptr_q] ? '0 : data_rdata_i;
        x_mem_result_err_o   = data_err_i;
      end
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values,
  // independent of the order the simulator evaluates processes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      hold_addr_q  <= '0;
      hold_we_q    <= 1'b0;
      hold_be_q    <= '0;
      hold_wdata_q <= '0;
      hold_id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (hold_load) begin
        hold_addr_q  <= x_mem_req_addr_i;
        hold_we_q    <= x_mem_req_we_i;
        hold_be_q    <= x_mem_req_be_i;
        hold_wdata_q <= x_mem_req_wdata_i;
        hold_id_q    <= x_mem_req_id_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: the entry storage has no reset; an entry is only read after being written,
  // and validity is carried entirely by the reset pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_id_q[wr_ptr_q] <= push_id;
      fifo_we_q[wr_ptr_q] <= push_we;
    end
  end

`ifndef SYNTHESIS
  logic                  prev_stall_q;
  logic [ADDR_WIDTH-1:0] prev_addr_q;
  logic                  prev_we_q;
  logic [BE_W-1:0]       prev_be_q;
  logic [DATA_WIDTH-1:0] prev_wdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_stall_q <= 1'b0;
      prev_addr_q  <= '0;
      prev_we_q    <= 1'b0;
      prev_be_q    <= '0;
      prev_wdata_q <= '0;
    end else begin
      prev_stall_q <= data_req_o & ~data_gnt_i;
      prev_addr_q  <= data_addr_o;
      prev_we_q    <= data_we_o;
      prev_be_q    <= data_be_o;
      prev_wdata_q <= data_wdata_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (prev_stall_q)
        assert (data_req_o && data_addr_o == prev_addr_q && data_we_o == prev_we_q &&
                data_be_o == prev_be_q && data_wdata_o == prev_wdata_q)
          else $error("OBI request changed before grant");
      assert (cnt_q <= CNT_W'(OUTSTANDING))
        else $error("outstanding count above limit");
      if (data_rvalid_i)
        assert (!fifo_empty)
          else $warning("data_rvalid_i with no outstanding transaction dropped");
    end
  end
`endif

endmodule

// File: tb/tb_fpu_ss_mem_responder.sv
// Bench for fpu_ss_mem_responder: directed scenarios plus a randomized run checked
// against a queue-based model of outstanding transactions.
module tb_fpu_ss_mem_responder;
  localparam int X_ID_WIDTH  = 4;
  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int OUTSTANDING = 2;
  localparam int NUM_RAND    = 80;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        x_mem_valid_i, x_mem_ready_o;
  logic [3:0]  x_mem_req_id_i;
  logic [31:0] x_mem_req_addr_i;
  logic        x_mem_req_we_i;
  logic [3:0]  x_mem_req_be_i;
  logic [31:0] x_mem_req_wdata_i;
  logic        x_mem_req_last_i, x_mem_req_spec_i;
  logic        x_mem_resp_exc_o;
  logic [5:0]  x_mem_resp_exccode_o;
  logic        x_mem_result_valid_o;
  logic [3:0]  x_mem_result_id_o;
  logic [31:0] x_mem_result_rdata_o;
  logic        x_mem_result_err_o;
  logic        data_req_o, data_gnt_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        data_err_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  fpu_ss_mem_responder #(
    .X_ID_WIDTH(X_ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH), .OUTSTANDING(OUTSTANDING)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .x_mem_valid_i(x_mem_valid_i), .x_mem_ready_o(x_mem_ready_o),
    .x_mem_req_id_i(x_mem_req_id_i), .x_mem_req_addr_i(x_mem_req_addr_i),
    .x_mem_req_we_i(x_mem_req_we_i), .x_mem_req_be_i(x_mem_req_be_i),
    .x_mem_req_wdata_i(x_mem_req_wdata_i), .x_mem_req_last_i(x_mem_req_last_i),
    .x_mem_req_spec_i(x_mem_req_spec_i),
    .x_mem_resp_exc_o(x_mem_resp_exc_o), .x_mem_resp_exccode_o(x_mem_resp_exccode_o),
    .x_mem_result_valid_o(x_mem_result_valid_o), .x_mem_result_id_o(x_mem_result_id_o),
    .x_mem_result_rdata_o(x_mem_result_rdata_o), .x_mem_result_err_o(x_mem_result_err_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
  );

  function automatic logic [127:0] all_outputs();
    return 128'({x_mem_ready_o, x_mem_resp_exc_o, x_mem_resp_exccode_o, x_mem_result_valid_o,
                 x_mem_result_id_o, x_mem_result_rdata_o, x_mem_result_err_o, data_req_o,
                 data_addr_o, data_we_o, data_be_o, data_wdata_o});
  endfunction

  task automatic idle_inputs();
    x_mem_valid_i     = 1'b0;
    x_mem_req_id_i    = '0;
    x_mem_req_addr_i  = '0;
    x_mem_req_we_i    = 1'b0;
    x_mem_req_be_i    = '0;
    x_mem_req_wdata_i = '0;
    x_mem_req_last_i  = 1'b1;
    x_mem_req_spec_i  = 1'b0;
    data_gnt_i        = 1'b0;
    data_rvalid_i     = 1'b0;
    data_rdata_i      = '0;
    data_err_i        = 1'b0;
  endtask

  task automatic drive_req(input logic [3:0] id, input logic [31:0] addr, input logic we,
                           input logic [3:0] be, input logic [31:0] wdata);
    x_mem_valid_i     = 1'b1;
    x_mem_req_id_i    = id;
    x_mem_req_addr_i  = addr;
    x_mem_req_we_i    = we;
    x_mem_req_be_i    = be;
    x_mem_req_wdata_i = wdata;
  endtask

  task automatic test_reset();
    idle_inputs();
    drive_req(4'd1, 32'h100, 1'b0, 4'hF, '0);
    data_rvalid_i = 1'b1;
    #1;
    n_tests++; if (all_outputs() !== 128'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all_outputs()); end
    @(negedge clk_i); idle_inputs(); rst_ni = 1'b1; #1;
    n_tests++; if ({x_mem_ready_o, data_req_o, x_mem_result_valid_o} !== 3'b100) begin n_fail++;
      $display("FAIL reset_release: ready/req/res got %b want 100", {x_mem_ready_o, data_req_o, x_mem_result_valid_o}); end
  endtask

  task automatic test_load();
    @(negedge clk_i); idle_inputs(); drive_req(4'd3, 32'h100, 1'b0, 4'hF, '0); data_gnt_i = 1'b1; #1;
    n_tests++; if ({x_mem_ready_o, data_req_o, data_addr_o, data_we_o} !== {1'b1, 1'b1, 32'h100, 1'b0}) begin n_fail++;
      $display("FAIL load_issue: got %b %b %h %b want 1 1 100 0", x_mem_ready_o, data_req_o, data_addr_o, data_we_o); end
    @(negedge clk_i); idle_inputs(); #1;
    n_tests++; if (x_mem_result_valid_o !== 1'b0) begin n_fail++; $display("FAIL load_early_result: got %b want 0", x_mem_result_valid_o); end
    @(negedge clk_i); data_rvalid_i = 1'b1; data_rdata_i = 32'h3F80_0000; #1;
    n_tests++; if ({x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o, x_mem_result_err_o} !== {1'b1, 4'd3, 32'h3F80_0000, 1'b0}) begin n_fail++;
      $display("FAIL load_result: got %b %0d %h %b want 1 3 3f800000 0", x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o, x_mem_result_err_o); end
    @(negedge clk_i); idle_inputs(); #1;
    n_tests++; if (x_mem_result_valid_o !== 1'b0) begin n_fail++; $display("FAIL load_single_pulse: got %b want 0", x_mem_result_valid_o); end
  endtask

  task automatic test_store_delayed_gnt();
    @(negedge clk_i); idle_inputs(); drive_req(4'd5, 32'h204, 1'b1, 4'hF, 32'hDEAD_BEEF); #1;
    n_tests++; if (data_req_o !== 1'b1) begin n_fail++; $display("FAIL store_req: got %b want 1", data_req_o); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i); idle_inputs(); #1;
      n_tests++; if ({x_mem_ready_o, data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o} !== {1'b0, 1'b1, 32'h204, 1'b1, 4'hF, 32'hDEAD_BEEF}) begin n_fail++;
        $display("FAIL store_hold: got rdy=%b req=%b %h %b %h %h", x_mem_ready_o, data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o); end
    end
    @(negedge clk_i); drive_req(4'd6, 32'h300, 1'b0, 4'hF, '0); data_gnt_i = 1'b1; #1;
    n_tests++; if ({x_mem_ready_o, data_req_o, data_addr_o, data_wdata_o} !== {1'b0, 1'b1, 32'h204, 32'hDEAD_BEEF}) begin n_fail++;
      $display("FAIL store_grant: got rdy=%b req=%b %h %h want 0 1 204 deadbeef", x_mem_ready_o, data_req_o, data_addr_o, data_wdata_o); end
    @(negedge clk_i); #1;
    n_tests++; if ({x_mem_ready_o, data_req_o, data_addr_o} !== {1'b1, 1'b1, 32'h300}) begin n_fail++;
      $display("FAIL next_after_grant: got rdy=%b req=%b %h want 1 1 300", x_mem_ready_o, data_req_o, data_addr_o); end
    @(negedge clk_i); idle_inputs(); data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678; #1;
    n_tests++; if ({x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o, x_mem_result_err_o} !== {1'b1, 4'd5, 32'h0, 1'b0}) begin n_fail++;
      $display("FAIL store_result: got %b %0d %h %b want 1 5 0 0", x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o, x_mem_result_err_o); end
    @(negedge clk_i); data_rdata_i = 32'hCAFE_F00D; #1;
    n_tests++; if ({x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o} !== {1'b1, 4'd6, 32'hCAFE_F00D}) begin n_fail++;
      $display("FAIL load6_result: got %b %0d %h want 1 6 cafef00d", x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o); end
    @(negedge clk_i); idle_inputs(); #1;
  endtask

  task automatic test_back_to_back_full();
    logic [31:0] rd [3];
    rd[0] = 32'hA1; rd[1] = 32'hA2; rd[2] = 32'hA3;
    @(negedge clk_i); idle_inputs(); drive_req(4'd1, 32'h10, 1'b0, 4'hF, '0); data_gnt_i = 1'b1; #1;
    n_tests++; if (x_mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b want 1", x_mem_ready_o); end
    @(negedge clk_i); drive_req(4'd2, 32'h14, 1'b0, 4'hF, '0); #1;
    n_tests++; if (x_mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready2: got %b want 1", x_mem_ready_o); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i); drive_req(4'd3, 32'h18, 1'b0, 4'hF, '0); #1;
      n_tests++; if ({x_mem_ready_o, data_req_o} !== 2'b00) begin n_fail++; $display("FAIL b2b_stall: got rdy/req %b want 00", {x_mem_ready_o, data_req_o}); end
    end
    @(negedge clk_i); data_rvalid_i = 1'b1; data_rdata_i = rd[0]; #1;
    n_tests++; if ({x_mem_ready_o, data_req_o, x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o} !== {2'b00, 1'b1, 4'd1, rd[0]}) begin n_fail++;
      $display("FAIL b2b_first_result: got rdy=%b req=%b %b %0d %h", x_mem_ready_o, data_req_o, x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o); end
    @(negedge clk_i); data_rdata_i = rd[1]; #1;
    n_tests++; if ({x_mem_ready_o, data_req_o, data_addr_o, x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o} !== {2'b11, 32'h18, 1'b1, 4'd2, rd[1]}) begin n_fail++;
      $display("FAIL b2b_second_result: got rdy=%b req=%b %h %b %0d %h", x_mem_ready_o, data_req_o, data_addr_o, x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o); end
    @(negedge clk_i); idle_inputs(); data_rvalid_i = 1'b1; data_rdata_i = rd[2]; #1;
    n_tests++; if ({x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o} !== {1'b1, 4'd3, rd[2]}) begin n_fail++;
      $display("FAIL b2b_third_result: got %b %0d %h want 1 3 a3", x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o); end
    @(negedge clk_i); idle_inputs(); #1;
    n_tests++; if (x_mem_result_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", x_mem_result_valid_o); end
  endtask

  task automatic test_misaligned();
    @(negedge clk_i); idle_inputs(); drive_req(4'd8, 32'h102, 1'b0, 4'hF, '0); #1;
    n_tests++; if ({x_mem_ready_o, x_mem_resp_exc_o, x_mem_resp_exccode_o, data_req_o} !== {1'b1, 1'b1, 6'd4, 1'b0}) begin n_fail++;
      $display("FAIL misaligned_load: got rdy=%b exc=%b code=%0d req=%b want 1 1 4 0", x_mem_ready_o, x_mem_resp_exc_o, x_mem_resp_exccode_o, data_req_o); end
    @(negedge clk_i); drive_req(4'd9, 32'h201, 1'b1, 4'hF, 32'h55); #1;
    n_tests++; if ({x_mem_ready_o, x_mem_resp_exc_o, x_mem_resp_exccode_o, data_req_o} !== {1'b1, 1'b1, 6'd6, 1'b0}) begin n_fail++;
      $display("FAIL misaligned_store: got rdy=%b exc=%b code=%0d req=%b want 1 1 6 0", x_mem_ready_o, x_mem_resp_exc_o, x_mem_resp_exccode_o, data_req_o); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i); idle_inputs(); #1;
      n_tests++; if ({x_mem_resp_exc_o, x_mem_resp_exccode_o, x_mem_result_valid_o, x_mem_ready_o} !== {1'b0, 6'd0, 1'b0, 1'b1}) begin n_fail++;
        $display("FAIL misaligned_after: got exc=%b code=%0d res=%b rdy=%b", x_mem_resp_exc_o, x_mem_resp_exccode_o, x_mem_result_valid_o, x_mem_ready_o); end
    end
  endtask

  task automatic test_bus_error();
    logic [31:0] r;
    r = $urandom;
    @(negedge clk_i); idle_inputs(); drive_req(4'd7, 32'h40, 1'b0, 4'hF, '0); data_gnt_i = 1'b1; #1;
    n_tests++; if (data_req_o !== 1'b1) begin n_fail++; $display("FAIL err_req: got %b want 1", data_req_o); end
    @(negedge clk_i); idle_inputs(); data_rvalid_i = 1'b1; data_err_i = 1'b1; data_rdata_i = r; #1;
    n_tests++; if ({x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o, x_mem_result_err_o} !== {1'b1, 4'd7, r, 1'b1}) begin n_fail++;
      $display("FAIL err_result: got %b %0d %h %b want 1 7 %h 1", x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o, x_mem_result_err_o, r); end
    @(negedge clk_i); idle_inputs(); data_rvalid_i = 1'b1; data_rdata_i = $urandom; #1;
    n_tests++; if (x_mem_result_valid_o !== 1'b0) begin n_fail++; $display("FAIL spurious_rvalid: got %b want 0", x_mem_result_valid_o); end
    @(negedge clk_i); idle_inputs(); #1;
  endtask

  task automatic test_random();
    req_t        cur, held, head;
    req_t        outq[$];
    bit          have = 0, waiting = 0;
    int          left = NUM_RAND;
    int          cyc = 0;
    logic        mis, exp_ready, exp_req, exp_exc, rv, gnt, err;
    logic [5:0]  exp_code;
    logic [31:0] rdata, a;
    while ((left > 0 || have || waiting || outq.size() > 0) && cyc < 4000) begin
      @(negedge clk_i); cyc++;
      idle_inputs();
      if (!have && left > 0 && $urandom_range(3) != 0) begin
        a = $urandom;
        if ($urandom_range(5) != 0) a[1:0] = 2'b00;
        cur.id = 4'($urandom); cur.addr = a; cur.we = 1'($urandom);
        cur.be = 4'($urandom); cur.wdata = $urandom;
        have = 1; left--;
      end
      if (have) drive_req(cur.id, cur.addr, cur.we, cur.be, cur.wdata);
      gnt   = 1'($urandom_range(1));
      rv    = (outq.size() > 0) && ($urandom_range(1) == 1);
      rdata = $urandom;
      err   = ($urandom_range(7) == 0);
      data_gnt_i = gnt; data_rvalid_i = rv; data_rdata_i = rdata; data_err_i = err;
      #1;
      mis       = have && (cur.addr[1:0] != 2'b00);
      exp_ready = !waiting && (outq.size() < OUTSTANDING);
      exp_req   = waiting || (have && !mis && exp_ready);
      exp_exc   = have && exp_ready && mis;
      exp_code  = exp_exc ? (cur.we ? 6'd6 : 6'd4) : 6'd0;
      n_tests++; if ({x_mem_ready_o, data_req_o, x_mem_resp_exc_o, x_mem_resp_exccode_o} !== {exp_ready, exp_req, exp_exc, exp_code}) begin n_fail++;
        $display("FAIL rand_ctrl cyc %0d: got rdy=%b req=%b exc=%b code=%0d want %b %b %b %0d", cyc,
                 x_mem_ready_o, data_req_o, x_mem_resp_exc_o, x_mem_resp_exccode_o, exp_ready, exp_req, exp_exc, exp_code); end
      if (exp_req) begin
        head = waiting ? held : cur;
        n_tests++; if ({data_addr_o, data_we_o, data_be_o, data_wdata_o} !== {head.addr, head.we, head.be, head.wdata}) begin n_fail++;
          $display("FAIL rand_obi cyc %0d: got %h %b %h %h want %h %b %h %h", cyc, data_addr_o, data_we_o, data_be_o, data_wdata_o,
                   head.addr, head.we, head.be, head.wdata); end
      end
      if (rv) begin
        head = outq.pop_front();
        n_tests++; if ({x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o, x_mem_result_err_o} !== {1'b1, head.id, head.we ? 32'h0 : rdata, err}) begin n_fail++;
          $display("FAIL rand_result cyc %0d: got %b %0d %h %b want 1 %0d %h %b", cyc, x_mem_result_valid_o, x_mem_result_id_o,
                   x_mem_result_rdata_o, x_mem_result_err_o, head.id, head.we ? 32'h0 : rdata, err); end
      end else begin
        n_tests++; if (x_mem_result_valid_o !== 1'b0) begin n_fail++; $display("FAIL rand_no_result cyc %0d: got %b want 0", cyc, x_mem_result_valid_o); end
      end
      if (waiting && gnt) begin
        outq.push_back(held); waiting = 0;
      end else if (have && exp_ready) begin
        have = 0;
        if (!mis) begin
          if (gnt) outq.push_back(cur);
          else begin held = cur; waiting = 1; end
        end
      end
    end
    n_tests++; if (cyc >= 4000) begin n_fail++; $display("FAIL rand_timeout: got %0d cycles want < 4000", cyc); end
    @(negedge clk_i); idle_inputs();
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk_i); idle_inputs(); drive_req(4'd1, 32'h50, 1'b0, 4'hF, '0); data_gnt_i = 1'b1;
    @(negedge clk_i); drive_req(4'd2, 32'h54, 1'b1, 4'hF, 32'h77); data_gnt_i = 1'b0;
    @(negedge clk_i); idle_inputs(); #1;
    n_tests++; if ({x_mem_ready_o, data_req_o, data_addr_o} !== {1'b0, 1'b1, 32'h54}) begin n_fail++;
      $display("FAIL midop_setup: got rdy=%b req=%b %h want 0 1 54", x_mem_ready_o, data_req_o, data_addr_o); end
    #1; rst_ni = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h99; drive_req(4'd4, 32'h60, 1'b0, 4'hF, '0); #1;
    n_tests++; if (all_outputs() !== 128'h0) begin n_fail++; $display("FAIL midop_reset_outputs: got %h want 0", all_outputs()); end
    @(negedge clk_i); idle_inputs(); rst_ni = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'h98; #1;
    n_tests++; if ({x_mem_result_valid_o, x_mem_ready_o, data_req_o} !== 3'b010) begin n_fail++;
      $display("FAIL midop_late_rvalid: got res/rdy/req %b want 010", {x_mem_result_valid_o, x_mem_ready_o, data_req_o}); end
    @(negedge clk_i); idle_inputs(); #1;
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_delayed_gnt();
    test_back_to_back_full();
    test_misaligned();
    test_bus_error();
    test_random();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
